// File: rtl/can_pkg.sv
// Shared types and constants for the CAN receive bit sampler.
package can_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } can_state_e;

  localparam int unsigned CAN_STUFF_LIMIT = 5;
  localparam int unsigned CAN_IDLE_BITS   = 11;

endpackage

// File: rtl/can_rx_bit_sampler_if.sv
// Bus-side and decoder-side signals of the CAN receive bit sampler.
interface can_rx_bit_sampler_if;
  logic CAN_RX;
  logic destuff_en;
  logic rx_bit;
  logic rx_bit_valid;
  logic rx_sof;
  logic stuff_error;
  logic bus_idle;

  modport master (
    output CAN_RX,
    output destuff_en,
    input  rx_bit,
    input  rx_bit_valid,
    input  rx_sof,
    input  stuff_error,
    input  bus_idle
  );

  modport slave (
    input  CAN_RX,
    input  destuff_en,
    output rx_bit,
    output rx_bit_valid,
    output rx_sof,
    output stuff_error,
    output bus_idle
  );
endinterface

// File: rtl/can_bit_timing.sv
// CAN bit timing: tq prescaler, quantum counter, hard sync and sample-point tick.
// SJW=1 resynchronization is built only when CAN_RX_RESYNC_EN is defined.
module can_bit_timing #(
  parameter int unsigned BRP   = 4,
  parameter int unsigned TSEG1 = 5,
  parameter int unsigned TSEG2 = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic hard_sync_i,
  input  logic resync_edge_i,
  output logic sample_tick_o
);

  localparam int unsigned QMax = TSEG1 + TSEG2;
  localparam int unsigned PW   = (BRP > 1) ? $clog2(BRP) : 1;
  localparam int unsigned QW   = $clog2(QMax + 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [QW-1:0] q_q, q_d;
  logic          tq_tick;
  logic          hold_now;
  logic          wrap_now;

  assign tq_tick       = run_i && (presc_q == PW'(BRP - 1));
  assign sample_tick_o = tq_tick && (q_q == QW'(TSEG1)) && !hold_now;

`ifdef CAN_RX_RESYNC_EN
  logic hold_q, hold_d;
  logic wrap_q, wrap_d;
  logic edge_early, edge_late;

  // Edges at q==0 are on time and need no correction.
  assign edge_early = resync_edge_i && (q_q != '0) && (q_q <= QW'(TSEG1));
  assign edge_late  = resync_edge_i && (q_q > QW'(TSEG1));
  assign hold_now   = hold_q | edge_early;
  assign wrap_now   = wrap_q | edge_late;

  always_comb begin
    hold_d = hold_q;
    wrap_d = wrap_q;
    if (edge_early) begin
      hold_d = 1'b1;
      wrap_d = 1'b0;
    end
    if (edge_late) begin
      wrap_d = 1'b1;
      hold_d = 1'b0;
    end
    if (hard_sync_i || tq_tick) begin
      hold_d = 1'b0;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      wrap_q <= wrap_d;
    end
  end
`else
  logic unused_resync_edge;
  assign unused_resync_edge = resync_edge_i;
  assign hold_now           = 1'b0;
  assign wrap_now           = 1'b0;
`endif

  always_comb begin
    presc_d = presc_q;
    q_d     = q_q;
    if (hard_sync_i) begin
      presc_d = '0;
      q_d     = '0;
    end else if (tq_tick) begin
      presc_d = '0;
      // A pending hold stretches the current quantum by repeating it.
      if (wrap_now || (q_q == QW'(QMax))) begin
        q_d = '0;
      end else if (!hold_now) begin
        q_d = q_q + QW'(1);
      end
    end else if (run_i) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      q_q     <= '0;
    end else begin
      presc_q <= presc_d;
      q_q     <= q_d;
    end
  end

endmodule

// File: rtl/can_rx_bit_sampler.sv
// CAN receive front end: synchronizer, bus-state FSM, destuffer and bit strobes.
// Define CAN_RX_RESYNC_EN to enable SJW=1 resynchronization in can_bit_timing.
module can_rx_bit_sampler
  import can_pkg::*;
#(
  parameter int unsigned BRP   = 4,
  parameter int unsigned TSEG1 = 5,
  parameter int unsigned TSEG2 = 2
) (
  input  logic                 CLOCK_SIGNAL_IN,
  input  logic                 RESET,
  can_rx_bit_sampler_if.slave  bus
);

  logic       sync1_q, s_q, s_dly_q;
  logic       fall;
  can_state_e state_q, state_d;
  logic       sample_tick, hard_sync, resync_edge, timing_run;
  logic       smp_vld_q, smp_vld_d;
  logic       smp_bit_q, smp_bit_d;
  logic       smp_den_q, smp_den_d;
  logic [2:0] run_cnt_q, run_cnt_d;
  logic       last_q, last_d;
  logic [3:0] rec_cnt_q, rec_cnt_d;
  logic [3:0] rec_next;
  logic       rx_bit_q, rx_bit_d;
  logic       rx_vld_q, rx_vld_d;
  logic       rx_sof_q, rx_sof_d;
  logic       stuff_err_q, stuff_err_d;
  logic       bus_idle_q, bus_idle_d;

  always_ff @(posedge CLOCK_SIGNAL_IN or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
      s_dly_q <= 1'b1;
    end else begin
      sync1_q <= bus.CAN_RX;
      s_q     <= sync1_q;
      s_dly_q <= s_q;
    end
  end

  assign fall        = s_dly_q & ~s_q;
  assign hard_sync   = (state_q == IDLE) && fall;
  assign resync_edge = (state_q == ACTIVE) && fall;
  assign timing_run  = (state_q != IDLE);

  can_bit_timing #(
    .BRP   (BRP),
    .TSEG1 (TSEG1),
    .TSEG2 (TSEG2)
  ) u_timing (
    .clk_i         (CLOCK_SIGNAL_IN),
    .rst_i         (RESET),
    .run_i         (timing_run),
    .hard_sync_i   (hard_sync),
    .resync_edge_i (resync_edge),
    .sample_tick_o (sample_tick)
  );

  // Sample stage: capture the bus value and destuff qualifier at the sample point.
  always_comb begin
    smp_vld_d = sample_tick;
    smp_bit_d = sample_tick ? s_q : smp_bit_q;
    smp_den_d = sample_tick ? bus.destuff_en : smp_den_q;
  end

  assign rec_next = !smp_bit_q                     ? 4'd0 :
                    (rec_cnt_q == 4'(CAN_IDLE_BITS)) ? rec_cnt_q :
                    rec_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    last_d      = last_q;
    rec_cnt_d   = rec_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_vld_d    = 1'b0;
    rx_sof_d    = 1'b0;
    stuff_err_d = 1'b0;
    bus_idle_d  = bus_idle_q;

    unique case (state_q)
      WAIT_IDLE: begin
        if (smp_vld_q) begin
          rec_cnt_d = rec_next;
          if (!smp_den_q) begin
            run_cnt_d = 3'd1;
            last_d    = smp_bit_q;
          end
          if (rec_next == 4'(CAN_IDLE_BITS)) begin
            state_d    = IDLE;
            bus_idle_d = 1'b1;
          end
        end
      end
      IDLE: begin
        // Seeding last=recessive makes the dominant SOF start a fresh run of one.
        if (fall) begin
          state_d    = ACTIVE;
          rx_sof_d   = 1'b1;
          bus_idle_d = 1'b0;
          run_cnt_d  = 3'd1;
          last_d     = 1'b1;
          rec_cnt_d  = 4'd0;
        end
      end
      ACTIVE: begin
        if (smp_vld_q) begin
          rec_cnt_d = rec_next;
          if (!smp_den_q) begin
            run_cnt_d = 3'd1;
            last_d    = smp_bit_q;
            rx_vld_d  = 1'b1;
            rx_bit_d  = smp_bit_q;
          end else if (run_cnt_q == 3'(CAN_STUFF_LIMIT)) begin
            if (smp_bit_q != last_q) begin
              run_cnt_d = 3'd1;
              last_d    = smp_bit_q;
            end else begin
              stuff_err_d = 1'b1;
            end
          end else begin
            if (smp_bit_q == last_q) begin
              run_cnt_d = run_cnt_q + 3'd1;
            end else begin
              run_cnt_d = 3'd1;
              last_d    = smp_bit_q;
            end
            rx_vld_d = 1'b1;
            rx_bit_d = smp_bit_q;
          end

          if (stuff_err_d) begin
            state_d   = WAIT_IDLE;
            rec_cnt_d = 4'd0;
          end else if (rec_next == 4'(CAN_IDLE_BITS)) begin
            state_d    = IDLE;
            bus_idle_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_SIGNAL_IN or posedge RESET) begin
    if (RESET) begin
      state_q     <= WAIT_IDLE;
      smp_vld_q   <= 1'b0;
      smp_bit_q   <= 1'b1;
      smp_den_q   <= 1'b0;
      run_cnt_q   <= 3'd1;
      last_q      <= 1'b1;
      rec_cnt_q   <= 4'd0;
      rx_bit_q    <= 1'b1;
      rx_vld_q    <= 1'b0;
      rx_sof_q    <= 1'b0;
      stuff_err_q <= 1'b0;
      bus_idle_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_vld_q   <= smp_vld_d;
      smp_bit_q   <= smp_bit_d;
      smp_den_q   <= smp_den_d;
      run_cnt_q   <= run_cnt_d;
      last_q      <= last_d;
      rec_cnt_q   <= rec_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_vld_q    <= rx_vld_d;
      rx_sof_q    <= rx_sof_d;
      stuff_err_q <= stuff_err_d;
      bus_idle_q  <= bus_idle_d;
    end
  end

  assign bus.rx_bit       = rx_bit_q;
  assign bus.rx_bit_valid = rx_vld_q;
  assign bus.rx_sof       = rx_sof_q;
  assign bus.stuff_error  = stuff_err_q;
  assign bus.bus_idle     = bus_idle_q;

endmodule

// File: tb/tb_can_rx_bit_sampler.sv
// Scoreboard bench for can_rx_bit_sampler at BRP=4, TSEG1=5, TSEG2=2.
// Expected resync shift depends on CAN_RX_RESYNC_EN.
module tb_can_rx_bit_sampler;
  import can_pkg::*;

  localparam int KSof = 0;
  localparam int KBit = 1;
  localparam int KErr = 2;
`ifdef CAN_RX_RESYNC_EN
  localparam int ResyncShift = 4;
`else
  localparam int ResyncShift = 0;
`endif

  typedef struct {
    int   kind;
    logic val;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  can_rx_bit_sampler_if bus_if ();

  can_rx_bit_sampler #(
    .BRP   (4),
    .TSEG1 (5),
    .TSEG2 (2)
  ) dut (
    .CLOCK_SIGNAL_IN (clk),
    .RESET           (rst),
    .bus             (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input logic val, input int at);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, input logic val);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_strobe: kind %0d val %b at cycle %0d, required no strobe",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL strobe: got kind %0d val %b cycle %0d, required kind %0d val %b cycle %0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_strobe: kind %0d not seen, required at cycle %0d",
               exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (bus_if.rx_sof === 1'b1)       take(KSof, 1'b0);
    if (bus_if.rx_bit_valid === 1'b1) take(KBit, bus_if.rx_bit);
    if (bus_if.stuff_error === 1'b1)  take(KErr, 1'b0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input logic den, input int late);
    if (late > 0) tick(late);
    bus_if.CAN_RX     = b;
    bus_if.destuff_en = den;
    tick(32 - late);
  endtask

  task automatic wait_idle(input int limit, output int waited);
    waited = 0;
    while (bus_if.bus_idle !== 1'b1 && waited < limit) begin
      tick(1);
      waited++;
    end
    n_chk++;
    if (bus_if.bus_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_timeout: bus_idle still %b after %0d cycles, required 1",
               bus_if.bus_idle, limit);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int t0;
    bus_if.CAN_RX     = 1'b1;
    bus_if.destuff_en = 1'b0;
    rst               = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_bit", bus_if.rx_bit, 1);
    chk("rst_rx_bit_valid", bus_if.rx_bit_valid, 0);
    chk("rst_rx_sof", bus_if.rx_sof, 0);
    chk("rst_stuff_error", bus_if.stuff_error, 0);
    chk("rst_bus_idle", bus_if.bus_idle, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle(500, waited);
    chk("idle_after_reset_in_window", (waited >= 320 && waited <= 384), 1);

    // SOF and destuffing: 0,0,0,0,0,1(stuff),1 then recessive until idle
    t0 = cyc;
    push(KSof, 1'b0, t0 + 3);
    for (int k = 0; k < 16; k++) begin
      if (k != 5) push(KBit, (k < 5) ? 1'b0 : 1'b1, t0 + 28 + 32 * k);
    end
    for (int k = 0; k < 16; k++) begin
      drive_bit((k < 5) ? 1'b0 : 1'b1, (k <= 6), 0);
      if (k == 0) chk("bus_idle_low_after_sof", bus_if.bus_idle, 0);
    end
    chk("bus_idle_after_destuff_frame", bus_if.bus_idle, 1);

    // Stuff error: six dominant bits with destuffing on
    t0 = cyc;
    push(KSof, 1'b0, t0 + 3);
    for (int k = 0; k < 5; k++) push(KBit, 1'b0, t0 + 28 + 32 * k);
    push(KErr, 1'b0, t0 + 28 + 32 * 5);
    for (int k = 0; k < 6; k++) drive_bit(1'b0, 1'b1, 0);
    chk("state_wait_idle_after_error", (dut.state_q == WAIT_IDLE), 1);
    chk("bus_idle_low_after_error", bus_if.bus_idle, 0);
    for (int k = 6; k < 16; k++) drive_bit(1'b1, 1'b0, 0);
    chk("bus_idle_low_after_10_recessive", bus_if.bus_idle, 0);
    drive_bit(1'b1, 1'b0, 0);
    chk("bus_idle_after_11_recessive", bus_if.bus_idle, 1);

    // Resync: falling edge of bit 2 arrives at q=2
    t0 = cyc;
    push(KSof, 1'b0, t0 + 3);
    push(KBit, 1'b0, t0 + 28);
    push(KBit, 1'b1, t0 + 60);
    push(KBit, 1'b0, t0 + 92 + ResyncShift);
    for (int k = 3; k < 14; k++) push(KBit, 1'b1, t0 + 28 + 32 * k + ResyncShift);
    drive_bit(1'b0, 1'b0, 0);
    drive_bit(1'b1, 1'b0, 0);
    drive_bit(1'b0, 1'b0, 9);
    for (int k = 3; k < 15; k++) drive_bit(1'b1, 1'b0, 0);
    chk("bus_idle_after_resync_frame", bus_if.bus_idle, 1);

    // Mid-frame reset during bit 3
    t0 = cyc;
    push(KSof, 1'b0, t0 + 3);
    push(KBit, 1'b0, t0 + 28);
    push(KBit, 1'b1, t0 + 60);
    push(KBit, 1'b0, t0 + 92);
    drive_bit(1'b0, 1'b0, 0);
    drive_bit(1'b1, 1'b0, 0);
    drive_bit(1'b0, 1'b0, 0);
    bus_if.CAN_RX = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midframe_reset_rx_bit", bus_if.rx_bit, 1);
    chk("midframe_reset_bus_idle", bus_if.bus_idle, 0);
    tick(21);
    drive_bit(1'b0, 1'b0, 0);
    drive_bit(1'b1, 1'b0, 0);
    drive_bit(1'b0, 1'b0, 0);
    bus_if.CAN_RX = 1'b1;
    wait_idle(1000, waited);

    // Fresh hard sync after bus_idle
    t0 = cyc;
    push(KSof, 1'b0, t0 + 3);
    push(KBit, 1'b0, t0 + 28);
    for (int k = 1; k < 12; k++) push(KBit, 1'b1, t0 + 28 + 32 * k);
    drive_bit(1'b0, 1'b0, 0);
    for (int k = 1; k < 13; k++) drive_bit(1'b1, 1'b0, 0);
    chk("bus_idle_after_final_frame", bus_if.bus_idle, 1);

    tick(40);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
